// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures one record per retired instruction from the core's debug
//   write-back ports into a first-word fall-through FIFO. A small trigger FSM
//   decides which commits are recorded. Records drain to the trace host over
//   a valid/ready stream, and records lost to a full FIFO are counted.
// Ports
//   clk, rst_n        core clock, async active-low reset
//   trace_en          capture enable (level)
//   trig_mode         00 free-run, 01 start-on-PC, 10 stop-after-PC, 11 = 00
//   trig_pc           trigger PC compared against wb_pc
//   flush             sync clear of FIFO and drop counter
//   wb_*              debug write-back commit stream
//   out_valid/ready   record stream to the host
//   out_data          {wb_ena, wb_reg, wb_pc, wb_value}, zero when empty
//   fill_count        records held, 0..DEPTH
//   drop_cnt          saturating count of records lost to a full FIFO
//   trace_state       0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
module commit_trace_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int OVF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trace_en,
    input  logic [1:0]            trig_mode,
    input  logic [31:0]           trig_pc,
    input  logic                  flush,
    input  logic                  wb_have_inst,
    input  logic [31:0]           wb_pc,
    input  logic                  wb_ena,
    input  logic [4:0]            wb_reg,
    input  logic [31:0]           wb_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [69:0]           out_data,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic [OVF_W-1:0]      drop_cnt,
    output logic [1:0]            trace_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int REC_W = 70;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   pc_hit, capture, leave_idle;

    assign pc_hit = (wb_pc == trig_pc);

    // ---------------- trigger FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!trace_en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = (trig_mode == 2'b01) ? S_ARMED : S_CAPTURE;
                S_ARMED:   if (wb_have_inst && pc_hit) state_nxt = S_CAPTURE;
                S_CAPTURE: if (trig_mode == 2'b10 && wb_have_inst && pc_hit) state_nxt = S_DONE;
                default:   state_nxt = S_DONE;
            endcase
        end
    end

    // The trigger commit itself is recorded in both ARMED and CAPTURE, so
    // capture is decided from the current state, not the next one.
    always_comb begin
        capture     = 1'b0;
        leave_idle  = 1'b0;
        trace_state = state;
        case (state)
            S_IDLE:    leave_idle = trace_en;
            S_ARMED:   capture    = trace_en && wb_have_inst && pc_hit;
            S_CAPTURE: capture    = trace_en && wb_have_inst;
            default:   capture    = 1'b0;
        endcase
    end

    // ---------------- FIFO ----------------
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [REC_W-1:0] mem [DEPTH];
    logic             empty, full, pop, push, drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop   = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: nothing is visible until a push lands.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {wb_ena, wb_reg, wb_pc, wb_value};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        drop_cnt <= '0;
        else if (flush || leave_idle)      drop_cnt <= '0;
        else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + OVF_W'(1);
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign fill_count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en = 1'b0;
    logic [1:0]  trig_mode = 2'b00;
    logic [31:0] trig_pc = '0;
    logic        flush = 1'b0;
    logic        wb_have_inst = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_ena = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [69:0] out_data;
    logic [4:0]  fill_count;
    logic [15:0] drop_cnt;
    logic [1:0]  trace_state;

    int errors = 0;
    int checks = 0;

    commit_trace_buffer #(.DEPTH_LOG2(4), .OVF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .flush(flush), .wb_have_inst(wb_have_inst),
        .wb_pc(wb_pc), .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill_count(fill_count), .drop_cnt(drop_cnt), .trace_state(trace_state)
    );

    always #5 clk = ~clk;

    // Expected record for a commit driven by commit(): reg = pc[6:2], value = ~pc.
    function automatic logic [69:0] mk(input logic [31:0] pc);
        logic [4:0] r;
        r = pc[6:2];
        return {1'b1, r, pc, ~pc};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic commit(input logic [31:0] pc);
        wb_have_inst = 1'b1;
        wb_pc        = pc;
        wb_ena       = 1'b1;
        wb_reg       = pc[6:2];
        wb_value     = ~pc;
        tick();
        wb_have_inst = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", 70'(out_valid), 70'(0));
        chk("rst_fill",  70'(fill_count), 70'(0));
        chk("rst_drop",  70'(drop_cnt), 70'(0));
        chk("rst_state", 70'(trace_state), 70'(0));
        chk("rst_data",  out_data, 70'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T2 free-run, streaming with out_ready=1
        trace_en  = 1'b1;
        trig_mode = 2'b00;
        out_ready = 1'b1;
        tick();
        chk("t2_state", 70'(trace_state), 70'(2));
        commit(32'h00);
        chk("t2_v0", 70'(out_valid), 70'(1));
        chk("t2_d0", out_data, mk(32'h00));
        commit(32'h04);
        chk("t2_d1", out_data, mk(32'h04));
        chk("t2_f1", 70'(fill_count), 70'(1));
        commit(32'h08);
        chk("t2_d2", out_data, mk(32'h08));
        tick();
        chk("t2_empty", 70'(out_valid), 70'(0));
        chk("t2_zero",  out_data, 70'(0));
        chk("t2_drop",  70'(drop_cnt), 70'(0));

        // T3 overflow then drain
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) commit(32'h100 + 32'(4 * i));
        chk("t3_fill", 70'(fill_count), 70'(16));
        chk("t3_drop", 70'(drop_cnt), 70'(4));
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_rec%0d", i), out_data, mk(32'h100 + 32'(4 * i)));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_empty", 70'(out_valid), 70'(0));

        // T1 reset mid-stream
        for (int i = 0; i < 5; i++) commit(32'h200 + 32'(4 * i));
        chk("t1_fill5", 70'(fill_count), 70'(5));
        rst_n = 1'b0;
        #1;
        chk("t1_valid", 70'(out_valid), 70'(0));
        chk("t1_fill",  70'(fill_count), 70'(0));
        chk("t1_state", 70'(trace_state), 70'(0));
        chk("t1_drop",  70'(drop_cnt), 70'(0));
        trace_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T4 start-on-PC
        trig_mode = 2'b01;
        trig_pc   = 32'h40;
        trace_en  = 1'b1;
        tick();
        chk("t4_armed", 70'(trace_state), 70'(1));
        commit(32'h38);
        commit(32'h3C);
        chk("t4_pre_fill",  70'(fill_count), 70'(0));
        chk("t4_pre_state", 70'(trace_state), 70'(1));
        commit(32'h40);
        chk("t4_state", 70'(trace_state), 70'(2));
        commit(32'h44);
        chk("t4_fill", 70'(fill_count), 70'(2));
        out_ready = 1'b1;
        chk("t4_r0", out_data, mk(32'h40));
        tick();
        chk("t4_r1", out_data, mk(32'h44));
        tick();
        out_ready = 1'b0;
        trace_en  = 1'b0;
        tick();
        chk("t4_idle", 70'(trace_state), 70'(0));

        // T5 stop-after-PC
        trig_mode = 2'b10;
        trig_pc   = 32'h10;
        trace_en  = 1'b1;
        tick();
        commit(32'h08);
        commit(32'h0C);
        commit(32'h10);
        chk("t5_done", 70'(trace_state), 70'(3));
        commit(32'h14);
        commit(32'h18);
        chk("t5_fill", 70'(fill_count), 70'(3));
        trace_en = 1'b0;
        tick();
        chk("t5_idle", 70'(trace_state), 70'(0));
        out_ready = 1'b1;
        chk("t5_r0", out_data, mk(32'h08));
        tick();
        chk("t5_r1", out_data, mk(32'h0C));
        tick();
        chk("t5_r2", out_data, mk(32'h10));
        tick();
        chk("t5_empty", 70'(out_valid), 70'(0));
        out_ready = 1'b0;

        // T6 full with pop, then drop, then flush with commit
        trig_mode = 2'b00;
        trace_en  = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) commit(32'h300 + 32'(4 * i));
        chk("t6_full", 70'(fill_count), 70'(16));
        out_ready = 1'b1;
        commit(32'h400);
        out_ready = 1'b0;
        chk("t6_fill_pop", 70'(fill_count), 70'(16));
        chk("t6_drop_pop", 70'(drop_cnt), 70'(0));
        chk("t6_head",     out_data, mk(32'h304));
        commit(32'h404);
        chk("t6_drop1", 70'(drop_cnt), 70'(1));
        flush = 1'b1;
        commit(32'h408);
        flush = 1'b0;
        chk("t6_flush_fill",  70'(fill_count), 70'(0));
        chk("t6_flush_drop",  70'(drop_cnt), 70'(0));
        chk("t6_flush_state", 70'(trace_state), 70'(2));
        chk("t6_flush_valid", 70'(out_valid), 70'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
